retire_trace_checker: RTL

Parametrised, synthesisable self-checking monitor for the single-cycle RISC-V datapath. It replaces ad-hoc $monitor printing of instruction, PC and ALUResult with cycle-accurate comparison against an expected retirement stream. It counts mismatches, logs failing retirements in a readable FIFO, and detects hangs with a watchdog. It sits beside the datapath in the bench and can also be dropped into FPGA builds.

---
 rtl/retire_trace_checker.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/retire_trace_checker.sv
// Retirement-stream checker for a single-cycle RISC-V datapath: compares each
// retirement to an expected stream, counts mismatches, logs them, and watches for hangs.
module retire_trace_checker #(
  parameter int XLEN      = 64,
  parameter int ILEN      = 32,
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [ILEN-1:0]  instruction,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             exp_valid,
  input  logic [XLEN-1:0]  exp_pc,
  input  logic [ILEN-1:0]  exp_instr,
  input  logic [XLEN-1:0]  exp_alu,
  input  logic             exp_alu_chk,
  input  logic             exp_last,
  output logic             exp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             underflow,
  output logic             log_overflow,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] mismatch_count,
  input  logic             log_rd_en,
  output logic             log_empty,
  output logic [XLEN-1:0]  log_rd_pc,
  output logic [CNT_W-1:0] log_rd_idx
);

  localparam int AW   = $clog2(LOG_DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              log_empty_q, log_empty_d;
  logic [XLEN-1:0]   rd_pc_q, rd_pc_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;

  logic [XLEN-1:0]   log_pc_mem  [LOG_DEPTH];
  logic [CNT_W-1:0]  log_idx_mem [LOG_DEPTH];

  logic              log_full;
  logic              log_is_empty;
  logic              entry_mismatch;
  logic              log_push;

  // Valid/ready: an expected entry is consumed exactly on a cycle where the
  // checker is running, the datapath retires and an expected entry is offered.
  assign exp_ready = reset & busy_q & retire_valid & exp_valid;

  assign log_is_empty   = (wr_ptr_q == rd_ptr_q);
  assign log_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign entry_mismatch = (pc != exp_pc) || (instruction != exp_instr) ||
                          (exp_alu_chk && (alu_result != exp_alu));

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    underflow_d    = underflow_q;
    overflow_d     = overflow_q;
    retire_cnt_d   = retire_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    wd_d           = wd_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rd_pc_d        = rd_pc_q;
    rd_idx_d       = rd_idx_q;
    log_push       = 1'b0;

    // The log is poppable in every state; a restart below discards it.
    if (log_rd_en && !log_is_empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rd_pc_d  = log_pc_mem[rd_ptr_q[AW-1:0]];
      rd_idx_d = log_idx_mem[rd_ptr_q[AW-1:0]];
    end

    case (state_q)
      S_RUN: begin
        if (retire_valid) begin
          wd_d = '0;
          if (exp_valid) begin
            retire_cnt_d = (retire_cnt_q == '1) ? retire_cnt_q : retire_cnt_q + CNT_ONE;
            if (entry_mismatch) begin
              mismatch_cnt_d = (mismatch_cnt_q == '1) ? mismatch_cnt_q
                                                      : mismatch_cnt_q + CNT_ONE;
              if (!log_full) begin
                log_push = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
              end else begin
                overflow_d = 1'b1;
              end
            end
            if (exp_last) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (mismatch_cnt_d == '0) && !timeout_q && !underflow_q;
            end
          end else begin
            underflow_d = 1'b1;
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b0;
          end
        end else begin
          wd_d = wd_q + WD_ONE;
          if (wd_d == WD_LIM) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
          end
        end
      end
      default: begin
        if (start) begin
          state_d        = S_RUN;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          timeout_d      = 1'b0;
          underflow_d    = 1'b0;
          overflow_d     = 1'b0;
          retire_cnt_d   = '0;
          mismatch_cnt_d = '0;
          wd_d           = '0;
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
        end
      end
    endcase

    log_empty_d = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
      retire_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      wd_q           <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      log_empty_q    <= 1'b1;
      rd_pc_q        <= '0;
      rd_idx_q       <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      underflow_q    <= underflow_d;
      overflow_q     <= overflow_d;
      retire_cnt_q   <= retire_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      wd_q           <= wd_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      log_empty_q    <= log_empty_d;
      rd_pc_q        <= rd_pc_d;
      rd_idx_q       <= rd_idx_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (log_push) begin
      log_pc_mem[wr_ptr_q[AW-1:0]]  <= pc;
      log_idx_mem[wr_ptr_q[AW-1:0]] <= retire_cnt_q;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign underflow      = underflow_q;
  assign log_overflow   = overflow_q;
  assign retire_count   = retire_cnt_q;
  assign mismatch_count = mismatch_cnt_q;
  assign log_empty      = log_empty_q;
  assign log_rd_pc      = rd_pc_q;
  assign log_rd_idx     = rd_idx_q;

endmodule
